// File: rtl/cim_gemm_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cim_gemm_sequencer
// Description : Arbitrates weight writes and GeMM commands onto the single
//               Basic_GeMM_CIM port: CLEAR, ACCUM (activation beats), DRAIN.
//               Optional build macro: CIM_SEQ_ZERO_SKIP_EN (skip all-zero beats).
// Revision    : 1.0 - initial release
// ============================================================================
module cim_gemm_sequencer #(
  parameter int LEN_WIDTH = 8,
  parameter int NUM_OUT   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [31:0]          wr_addr,
  input  logic [31:0]          wr_data,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [31:0]          cmd_addr,
  input  logic [LEN_WIDTH-1:0] cmd_len,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_data,
  output logic [2:0]           out_idx,
  output logic                 out_last,
  output logic                 busy,
  output logic                 cim_cs,
  output logic                 cim_web,
  output logic                 cim_cimeb,
  output logic                 cim_psum_eb,
  output logic                 cim_reset_out,
  output logic [3:0]           cim_output_reg,
  output logic [31:0]          cim_address,
  output logic [31:0]          cim_input_data,
  input  logic [31:0]          cim_output
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_ACCUM = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

  logic [1:0]           state_q, state_d;
  logic [31:0]          base_q, base_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] beat_q, beat_d;
  logic [2:0]           idx_q, idx_d;

  logic                 out_valid_q;
  logic [31:0]          out_data_q;
  logic [2:0]           out_idx_q;
  logic                 out_last_q;

  logic w_last_beat;
  logic w_idx_last;
  logic w_load;
  logic w_skip;

  assign w_last_beat = (beat_q == (len_q - LEN_ONE));
  assign w_idx_last  = (idx_q == 3'(NUM_OUT - 1));
  assign w_load      = (state_q == S_DRAIN) && (!out_valid_q || out_ready);

`ifdef CIM_SEQ_ZERO_SKIP_EN
  // An all-zero activation word contributes nothing, so the array is left idle.
  assign w_skip = (in_data == 32'd0);
`else
  assign w_skip = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    len_d   = len_q;
    beat_d  = beat_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && !wr_valid) begin
          base_d  = cmd_addr;
          len_d   = cmd_len;
          beat_d  = '0;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        idx_d   = '0;
        state_d = (len_q != '0) ? S_ACCUM : S_DRAIN;
      end
      S_ACCUM: begin
        if (in_valid) begin
          beat_d = beat_q + LEN_ONE;
          if (w_last_beat) begin
            idx_d   = '0;
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (w_load) begin
          idx_d = idx_q + 3'd1;
          if (w_idx_last) begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q <= '0;
      len_q  <= '0;
      beat_q <= '0;
      idx_q  <= '0;
    end else begin
      base_q <= base_d;
      len_q  <= len_d;
      beat_q <= beat_d;
      idx_q  <= idx_d;
    end
  end

  // A new load takes priority over retiring the held result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
    end else if (w_load) begin
      out_valid_q <= 1'b1;
      out_data_q  <= cim_output;
      out_idx_q   <= idx_q;
      out_last_q  <= w_idx_last;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;

  always_comb begin
    wr_ready       = 1'b0;
    cmd_ready      = 1'b0;
    in_ready       = 1'b0;
    busy           = (state_q != S_IDLE);
    cim_cs         = 1'b0;
    cim_web        = 1'b0;
    cim_cimeb      = 1'b0;
    cim_psum_eb    = 1'b0;
    cim_reset_out  = 1'b0;
    cim_output_reg = 4'd0;
    cim_address    = 32'd0;
    cim_input_data = 32'd0;
    case (state_q)
      S_IDLE: begin
        wr_ready  = 1'b1;
        cmd_ready = !wr_valid;
        if (wr_valid) begin
          cim_cs         = 1'b1;
          cim_web        = 1'b1;
          cim_address    = wr_addr;
          cim_input_data = wr_data;
        end
      end
      S_CLEAR: begin
        cim_cs        = 1'b1;
        cim_cimeb     = 1'b1;
        cim_reset_out = 1'b1;
      end
      S_ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && !w_skip) begin
          cim_cs         = 1'b1;
          cim_cimeb      = 1'b1;
          cim_psum_eb    = 1'b1;
          cim_address    = base_q + (32'(beat_q) << 3);
          cim_input_data = in_data;
        end
      end
      S_DRAIN: begin
        cim_cimeb      = 1'b1;
        cim_output_reg = {1'b0, idx_q};
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_cim_gemm_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cim_gemm_sequencer
// Description : Directed bench with a behavioural Basic_GeMM_CIM macro model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cim_gemm_sequencer;
  localparam int LEN_WIDTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                 wr_valid = 0, wr_ready;
  logic [31:0]          wr_addr = 0, wr_data = 0;
  logic                 cmd_valid = 0, cmd_ready;
  logic [31:0]          cmd_addr = 0;
  logic [LEN_WIDTH-1:0] cmd_len = 0;
  logic                 in_valid = 0, in_ready;
  logic [31:0]          in_data = 0;
  logic                 out_valid, out_ready = 1;
  logic [31:0]          out_data;
  logic [2:0]           out_idx;
  logic                 out_last, busy;
  logic                 cim_cs, cim_web, cim_cimeb, cim_psum_eb, cim_reset_out;
  logic [3:0]           cim_output_reg;
  logic [31:0]          cim_address, cim_input_data, cim_output;

  cim_gemm_sequencer #(.LEN_WIDTH(LEN_WIDTH), .NUM_OUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .busy(busy),
    .cim_cs(cim_cs), .cim_web(cim_web), .cim_cimeb(cim_cimeb), .cim_psum_eb(cim_psum_eb),
    .cim_reset_out(cim_reset_out), .cim_output_reg(cim_output_reg),
    .cim_address(cim_address), .cim_input_data(cim_input_data), .cim_output(cim_output)
  );

  // Macro model: column c reads bytes c*128 + addr + lane; result = sum[13:8] sign-extended.
  logic [7:0]  mem [0:1023];
  logic [31:0] acc [0:7];
  logic [31:0] sel_acc;

  function automatic logic [31:0] dot(input int c, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] s;
    s = 32'd0;
    for (int l = 0; l < 8; l++)
      s = s + 32'(mem[10'(32'(c * 128) + a + 32'(l))]) * 32'(d[31 - 4*l -: 4]);
    return s;
  endfunction

  always @(posedge clk) begin
    if (cim_cs && cim_web)
      for (int b = 0; b < 4; b++) mem[10'(cim_address + 32'(b))] <= cim_input_data[31 - 8*b -: 8];
    if (cim_cs && cim_cimeb && cim_reset_out)
      for (int c = 0; c < 8; c++) acc[c] <= 32'd0;
    else if (cim_cs && cim_cimeb && cim_psum_eb)
      for (int c = 0; c < 8; c++) acc[c] <= acc[c] + dot(c, cim_address, cim_input_data);
  end

  assign sel_acc    = acc[cim_output_reg[2:0]];
  assign cim_output = {{26{sel_acc[13]}}, sel_acc[13:8]};

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int clr_cnt = 0;
  int psum_cnt = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (cim_reset_out) clr_cnt++;
    if (cim_psum_eb) psum_cnt++;
  end

  logic [31:0] beat_data [0:7];
  logic        beat_cs   [0:7];
  logic        beat_psum [0:7];
  logic [31:0] got_data  [0:7];
  logic [2:0]  got_idx   [0:7];
  logic        got_last  [0:7];
  logic [31:0] stall_data [0:7];
  logic [2:0]  stall_idx  [0:7];
  int          got_n, stall_n, first_valid_cyc, acc_cyc;
  logic        cmd_ready_at_last;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_cmd(input logic [31:0] a, input logic [LEN_WIDTH-1:0] l);
    bit ok;
    int n;
    n = 0;
    ok = 0;
    cmd_addr = a; cmd_len = l; cmd_valid = 1;
    while (!ok && n < 50) begin
      #1;
      ok = cmd_ready;
      step();
      n++;
    end
    cmd_valid = 0;
    acc_cyc = cyc;
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL cmd_accept_timeout: cmd_ready never seen within %0d cycles", n);
    end
  endtask

  task automatic send_beats(input int n);
    int i, t;
    bit ok;
    i = 0; t = 0;
    while (i < n && t < 100) begin
      in_valid = 1; in_data = beat_data[i];
      #1;
      ok = in_ready;
      if (ok) begin beat_cs[i] = cim_cs; beat_psum[i] = cim_psum_eb; end
      step();
      if (ok) i++;
      t++;
    end
    in_valid = 0; in_data = 0;
    if (i < n) begin
      n_tests++; n_fail++;
      $display("FAIL beat_timeout: sent %0d of %0d beats", i, n);
    end
  endtask

  task automatic collect(input bit bp);
    int t;
    t = 0; got_n = 0; stall_n = 0; first_valid_cyc = -1; cmd_ready_at_last = 0;
    while (got_n < 8 && t < 100) begin
      out_ready = bp ? (stall_n >= 5) : 1'b1;
      #1;
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (out_valid && !out_ready) begin
        stall_data[stall_n] = out_data; stall_idx[stall_n] = out_idx; stall_n++;
      end
      if (out_valid && out_ready) begin
        got_data[got_n] = out_data; got_idx[got_n] = out_idx; got_last[got_n] = out_last;
        if (got_n == 7) cmd_ready_at_last = cmd_ready;
        got_n++;
      end
      step();
      t++;
    end
    out_ready = 1;
    if (got_n < 8) begin
      n_tests++; n_fail++;
      $display("FAIL drain_timeout: received %0d of 8 results", got_n);
    end
  endtask

  task automatic test_reset();
    #2;
    n_tests++;
    if ({cmd_ready, wr_ready, busy, in_ready} !== 4'b1100) begin
      n_fail++; $display("FAIL reset_ready: got cmd/wr/busy/in=%b want 1100", {cmd_ready, wr_ready, busy, in_ready});
    end
    n_tests++;
    if ({out_valid, out_last, out_idx, out_data} !== 37'd0) begin
      n_fail++; $display("FAIL reset_out: got valid=%b last=%b idx=%0d data=%h want all 0", out_valid, out_last, out_idx, out_data);
    end
    n_tests++;
    if ({cim_cs, cim_web, cim_cimeb, cim_psum_eb, cim_reset_out, cim_output_reg, cim_address, cim_input_data} !== 73'd0) begin
      n_fail++; $display("FAIL reset_cim: cim pins not all 0 (cs=%b addr=%h)", cim_cs, cim_address);
    end
    step(); step();
    rst_n = 1;
    step();
  endtask

  task automatic load_weights();
    int bad;
    bad = 0;
    for (int w = 0; w < 256; w++) begin
      wr_valid = 1; wr_addr = 32'(4 * w); wr_data = {4{8'(8'h10 * (w / 32 + 1))}};
      #1;
      if (!(wr_ready && cim_cs && cim_web && cim_address == wr_addr)) bad++;
      step();
    end
    wr_valid = 0;
    n_tests++;
    if (bad !== 0) begin n_fail++; $display("FAIL write_beats: %0d of 256 beats not driven, want 0", bad); end
  endtask

  task automatic test_reset_mid_accum();
    issue_cmd(32'd0, 8'd4);
    beat_data[0] = 32'h22222222; beat_data[1] = 32'h22222222;
    send_beats(2);
    rst_n = 0;
    #1;
    n_tests++;
    if ({cmd_ready, busy, out_valid, cim_cs} !== 4'b1000) begin
      n_fail++; $display("FAIL reset_mid: got cmd_ready/busy/out_valid/cim_cs=%b want 1000", {cmd_ready, busy, out_valid, cim_cs});
    end
    step(); step();
    rst_n = 1;
    step();
    issue_cmd(32'd0, 8'd1);
    beat_data[0] = 32'h22222222;
    send_beats(1);
    collect(0);
    for (int c = 0; c < 8; c++) begin
      n_tests++;
      if (got_data[c] !== 32'(c + 1) || got_idx[c] !== 3'(c)) begin
        n_fail++; $display("FAIL post_reset_res%0d: got data=%0d idx=%0d want data=%0d idx=%0d", c, got_data[c], got_idx[c], c + 1, c);
      end
    end
  endtask

  task automatic test_basic();
    issue_cmd(32'd0, 8'd1);
    beat_data[0] = 32'h22222222;
    send_beats(1);
    collect(0);
    for (int c = 0; c < 8; c++) begin
      n_tests++;
      if (got_data[c] !== 32'(c + 1) || got_idx[c] !== 3'(c) || got_last[c] !== (c == 7)) begin
        n_fail++; $display("FAIL basic_res%0d: got data=%0d idx=%0d last=%b want data=%0d idx=%0d last=%b",
                           c, got_data[c], got_idx[c], got_last[c], c + 1, c, c == 7);
      end
    end
    n_tests++;
    if (first_valid_cyc - acc_cyc !== 3) begin
      n_fail++; $display("FAIL basic_latency: first out_valid %0d cycles after accept, want 3", first_valid_cyc - acc_cyc);
    end
    n_tests++;
    if (cmd_ready_at_last !== 1'b1) begin
      n_fail++; $display("FAIL basic_cmd_ready_at_last: got %b want 1", cmd_ready_at_last);
    end
    n_tests++;
    if ({busy, out_valid} !== 2'b00) begin
      n_fail++; $display("FAIL basic_idle_after: got busy/out_valid=%b want 00", {busy, out_valid});
    end
  endtask

  task automatic test_backpressure();
    issue_cmd(32'd0, 8'd1);
    beat_data[0] = 32'h22222222;
    send_beats(1);
    collect(1);
    n_tests++;
    if (stall_n !== 5) begin n_fail++; $display("FAIL bp_stall_cycles: got %0d want 5", stall_n); end
    for (int s = 0; s < 5 && s < stall_n; s++) begin
      n_tests++;
      if (stall_data[s] !== 32'd1 || stall_idx[s] !== 3'd0) begin
        n_fail++; $display("FAIL bp_hold%0d: got data=%0d idx=%0d want data=1 idx=0", s, stall_data[s], stall_idx[s]);
      end
    end
    for (int c = 0; c < 8; c++) begin
      n_tests++;
      if (got_data[c] !== 32'(c + 1) || got_idx[c] !== 3'(c)) begin
        n_fail++; $display("FAIL bp_res%0d: got data=%0d idx=%0d want data=%0d idx=%0d", c, got_data[c], got_idx[c], c + 1, c);
      end
    end
  endtask

  task automatic test_zero_len();
    int c0, p0;
    c0 = clr_cnt; p0 = psum_cnt;
    issue_cmd(32'd0, 8'd0);
    collect(0);
    n_tests++;
    if (clr_cnt - c0 !== 1) begin n_fail++; $display("FAIL zlen_clear_cycles: got %0d want 1", clr_cnt - c0); end
    n_tests++;
    if (psum_cnt - p0 !== 0) begin n_fail++; $display("FAIL zlen_psum_pulses: got %0d want 0", psum_cnt - p0); end
    for (int c = 0; c < 8; c++) begin
      n_tests++;
      if (got_data[c] !== 32'd0 || got_idx[c] !== 3'(c)) begin
        n_fail++; $display("FAIL zlen_res%0d: got data=%0d idx=%0d want data=0 idx=%0d", c, got_data[c], got_idx[c], c);
      end
    end
  endtask

  task automatic test_collision();
    wr_valid = 1; wr_addr = 32'd0; wr_data = 32'h10101010;
    cmd_valid = 1; cmd_addr = 32'd0; cmd_len = 8'd1;
    #1;
    n_tests++;
    if ({cim_cs, cim_web, cmd_ready, wr_ready} !== 4'b1101) begin
      n_fail++; $display("FAIL coll_write_wins: got cs/web/cmd_ready/wr_ready=%b want 1101", {cim_cs, cim_web, cmd_ready, wr_ready});
    end
    step();
    wr_valid = 0;
    #1;
    n_tests++;
    if ({busy, cmd_ready} !== 2'b01) begin
      n_fail++; $display("FAIL coll_second_cycle: got busy/cmd_ready=%b want 01", {busy, cmd_ready});
    end
    step();
    cmd_valid = 0;
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL coll_cmd_accept: got busy=%b want 1", busy); end
    beat_data[0] = 32'h22222222;
    send_beats(1);
    collect(0);
    for (int c = 0; c < 8; c++) begin
      n_tests++;
      if (got_data[c] !== 32'(c + 1)) begin
        n_fail++; $display("FAIL coll_res%0d: got %0d want %0d", c, got_data[c], c + 1);
      end
    end
  endtask

  task automatic test_zero_skip();
    logic exp_mid;
`ifdef CIM_SEQ_ZERO_SKIP_EN
    exp_mid = 1'b0;
`else
    exp_mid = 1'b1;
`endif
    beat_data[0] = 32'h22222222; beat_data[1] = 32'h00000000; beat_data[2] = 32'h22222222;
    issue_cmd(32'd0, 8'd3);
    send_beats(3);
    n_tests++;
    if ({beat_cs[0], beat_psum[0], beat_cs[2], beat_psum[2]} !== 4'b1111) begin
      n_fail++; $display("FAIL zskip_nonzero_beats: got cs/psum b0,b2=%b want 1111", {beat_cs[0], beat_psum[0], beat_cs[2], beat_psum[2]});
    end
    n_tests++;
    if (beat_cs[1] !== exp_mid) begin
      n_fail++; $display("FAIL zskip_mid_cs: got %b want %b", beat_cs[1], exp_mid);
    end
    collect(0);
    for (int c = 0; c < 8; c++) begin
      n_tests++;
      if (got_data[c] !== 32'(2 * (c + 1))) begin
        n_fail++; $display("FAIL zskip_res%0d: got %0d want %0d", c, got_data[c], 2 * (c + 1));
      end
    end
  endtask

  initial begin
    test_reset();
    load_weights();
    test_reset_mid_accum();
    test_basic();
    test_backpressure();
    test_zero_len();
    test_collision();
    test_zero_skip();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cim_gemm_sequencer.md
# cim_gemm_sequencer

Controller for the Basic_GeMM_CIM macro. It shares the macro's single port between a weight-write requester and a GeMM command requester. For each command it clears the macro's eight output accumulators, streams the packed 4-bit activation words into CIM mode at stepping addresses, then reads the eight ADC results out over a valid/ready stream. It sits between the core-side accelerator interface and the macro, and is the only block that drives the macro's control pins.

## Interface
Parameters:
- `LEN_WIDTH`, 8: width of the command beat count.
- `NUM_OUT`, 8: number of macro output registers drained per command. Fixed by the macro.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset. Asynchronous, active-low.
- `wr_valid` / `wr_ready`  in/out  1  weight-write handshake.
- `wr_addr`  in  32  byte address of the weight write.
- `wr_data`  in  32  four weight bytes, MSB byte at `wr_addr`.
- `cmd_valid` / `cmd_ready`  in/out  1  GeMM command handshake.
- `cmd_addr`  in  32  base weight address.
- `cmd_len`  in  LEN_WIDTH  number of activation beats (0 allowed).
- `in_valid` / `in_ready`  in/out  1  activation stream handshake.
- `in_data`  in  32  eight 4-bit activations, lane 0 in [31:28].
- `out_valid` / `out_ready`  out/in  1  result stream handshake.
- `out_data`  out  32  sign-extended 6-bit result.
- `out_idx`  out  3  result column index.
- `out_last`  out  1  high with index 7.
- `busy`  out  1  state is not IDLE.
- `cim_cs`, `cim_web`, `cim_cimeb`, `cim_psum_eb`, `cim_reset_out`  out  1  macro controls.
- `cim_output_reg`  out  4  macro output register select.
- `cim_address`  out  32  macro address.
- `cim_input_data`  out  32  macro input data.
- `cim_output`  in  32  macro combinational output.

## Operation
States are IDLE, CLEAR, ACCUM and DRAIN. Registers are `base`, `len`, `beat` (LEN_WIDTH) and `idx` (3 bits).

Macro pin defaults: all `cim_*` outputs are 0 unless a row below says otherwise. The `cim_*` outputs are combinational decodes of the state registers and the current handshakes.

- **IDLE**
  - `wr_ready=1`; `cmd_ready = !wr_valid`, so a write wins over a simultaneous command.
  - Write beat: `cim_cs=1`, `cim_web=1`, `cim_address=wr_addr`, `cim_input_data=wr_data`.
  - Command accept: latch `cmd_addr` and `cmd_len`, set `beat=0`, go to CLEAR.
- **CLEAR** (one cycle)
  - `cim_cs=1`, `cim_cimeb=1`, `cim_reset_out=1`.
  - Next state: ACCUM if `len!=0`, otherwise DRAIN with `idx=0`.
- **ACCUM**
  - `in_ready=1`.
  - On `in_valid`: `cim_cs=1`, `cim_cimeb=1`, `cim_psum_eb=1`, `cim_address = base + 8*beat` (32-bit, wraps modulo 2^32), `cim_input_data=in_data`, and `beat` increments.
  - After the beat where `beat==len-1` is accepted, go to DRAIN with `idx=0`.
- **DRAIN**
  - `cim_cimeb=1`, `cim_cs=0` (so nothing accumulates), `cim_output_reg={1'b0,idx}`.
  - Load condition is `!out_valid || out_ready`. On load:
    - `out_data <= cim_output`, `out_idx <= idx`, `out_last <= (idx==7)`, `out_valid <= 1`, `idx` increments.
  - After loading index 7, go to IDLE. The pending output may still be held there.
- **Output register**
  - `out_valid` clears on `out_ready` when no new load occurs in the same cycle.
  - While `out_valid && !out_ready`, `out_data`, `out_idx` and `out_last` hold stable.
- `in_ready` and `wr_ready` are 0 in every state not listed above.

Arithmetic:
- No math is done here. Results come from the macro, which returns sum bits [13:8] sign-extended to 32 bits.

Boundaries:
- `cmd_len=0`: sequence is CLEAR then DRAIN, and all eight outputs are 0.
- `in_valid` outside ACCUM is ignored.
- `cmd_valid` while busy is held off by `cmd_ready=0`.
- Reset mid-operation:
  - State goes to IDLE; counters, `out_valid`, `out_idx` and `out_last` reset.
  - Macro accumulators are not touched; the next command's CLEAR cleans them.

## Timing
Reset values:
- `cmd_ready=1`, `wr_ready=1`, `busy=0`.
- `in_ready=0`, `out_valid=0`, `out_data=0`, `out_idx=0`, `out_last=0`.
- All `cim_*` outputs = 0.

Latency, counted from the command accept edge E0:
- The CLEAR edge is E1.
- Beat k is accepted no earlier than edge E(2+k).
- With no input stalls, the first `out_valid` is seen after edge E(len+2).
- With `out_ready` held high, index 7 is seen after edge E(len+9), and `cmd_ready` rises in the same cycle.

Throughput:
- Write: one beat per cycle.
- Activations: one beat per cycle.
- Results: one per cycle.

## Configuration
- `CIM_SEQ_ZERO_SKIP_EN` defined:
  - In ACCUM, a beat with `in_data==0` is accepted and counted, but the macro pins stay at their defaults (no `cim_cs`). This saves array power.
  - Results are identical to the non-skip build.
- Undefined: every accepted beat drives a CIM cycle.

## Test plan
- **Reset.** Pulse `rst_n` low mid-ACCUM, then release.
  - Required: `cmd_ready=1`, `busy=0`, `out_valid=0`, `cim_cs=0`.
  - Then issue a fresh `cmd_addr=0`, `cmd_len=1` with `in_data=0x22222222` on the weights below. Outputs must match the basic GeMM case, so there is no stale accumulation.
- **Basic GeMM.** Write `mem[c*128+j]=0x10*(c+1)` for j in 0..127, c in 0..7, via 256 write beats. Then `cmd_addr=0`, `cmd_len=1`, `in_data=0x22222222`.
  - Required: `out_data` = c+1 for `out_idx` c = 0..7, with `out_last` only on index 7.
  - Required: with `out_ready=1`, `out_valid` first rises 3 cycles after the command accept.
- **Backpressure.** Same as the basic GeMM case, with `out_ready=0` for 5 cycles after the first `out_valid`.
  - Required: `out_data=1` and `out_idx=0` stay stable throughout.
  - Required: the full sequence 1..8 arrives with no loss.
- **Zero-length command.** `cmd_len=0`.
  - Required: exactly one CLEAR cycle and no `cim_psum_eb` pulse.
  - Required: eight outputs, all 0.
- **Write/command collision.** `wr_valid` and `cmd_valid` high in the same IDLE cycle.
  - Required: the write drives `cim_web=1` that cycle, `cmd_ready=0`.
  - Required: the command is accepted the next cycle.
- **Zero-skip (built with `CIM_SEQ_ZERO_SKIP_EN`).** `cmd_len=3` with `in_data` = 0x22222222, 0x00000000, 0x22222222.
  - Required: `cim_cs` is low on the middle beat.
  - Required: `out_data` = 2*(c+1).
